// File: rtl/mul_scheduler.sv
// Round-robin front end that shares one sequential multiplier between two requesters.
// Grant to mul_start is 1 cycle; response is 1 cycle after mul_done (or after TIMEOUT wait cycles); requesters hold req until ack.
module mul_scheduler #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic       mul_start,
  output logic [3:0] mul_multiplicand,
  output logic [3:0] mul_multiplier,
  input  logic [7:0] mul_product,
  input  logic       mul_done,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_product,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       id_q, id_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_product_q, rsp_product_d;
  logic       rsp_err_q, rsp_err_d;

  logic grant_any;
  logic grant_id;
  logic grant_en;

  // With both requesting, the one not served last wins; a lone requester always wins.
  assign grant_any = req0 | req1;
  assign grant_id  = (req0 & req1) ? ~last_grant_q : req1;
  assign grant_en  = (state_q == S_IDLE) & grant_any & ~rst;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    ack0          = 1'b0;
    ack1          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          ack0         = ~grant_id;
          ack1         = grant_id;
          a_d          = grant_id ? a1 : a0;
          b_d          = grant_id ? b1 : b0;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = 8'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the final wait cycle takes precedence over the timeout.
        if (mul_done) begin
          rsp_id_d      = id_q;
          rsp_product_d = mul_product;
          rsp_err_d     = 1'b0;
          state_d       = S_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          rsp_id_d      = id_q;
          rsp_product_d = 8'd0;
          rsp_err_d     = 1'b1;
          state_d       = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      wait_cnt_q    <= 8'd0;
      a_q           <= 4'd0;
      b_q           <= 4'd0;
      id_q          <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= 8'd0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      wait_cnt_q    <= wait_cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      id_q          <= id_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign mul_start        = (state_q == S_ISSUE);
  assign rsp_valid        = (state_q == S_RESP);
  assign busy             = (state_q != S_IDLE);
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;
  assign rsp_id           = rsp_id_q;
  assign rsp_product      = rsp_product_q;
  assign rsp_err          = rsp_err_q;

endmodule

// File: doc/mul_scheduler.md
MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 31: number of WAIT cycles allowed without mul_done before an error response (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  request from requester 0/1; held high with stable operands until the matching ack.
REQ-005 SHALL have ports a0/a1  input  4  multiplicand of requester 0/1.
REQ-006 SHALL have ports b0/b1  input  4  multiplier of requester 0/1.
REQ-007 SHALL have ports ack0/ack1  output  1  one-cycle grant pulse; the operands are captured on this edge.
REQ-008 SHALL have port mul_start  output  1  one-cycle start pulse to the shared sequential multiplier.
REQ-009 SHALL have ports mul_multiplicand/mul_multiplier  output  4  operands to the multiplier, held stable from ISSUE through WAIT.
REQ-010 SHALL have port mul_product  input  8  multiplier result, valid while mul_done is high.
REQ-011 SHALL have port mul_done  input  1  multiplier completion pulse.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_id  output  1  requester the response belongs to.
REQ-014 SHALL have port rsp_product  output  8  captured product; 0 on error.
REQ-015 SHALL have port rsp_err  output  1  set when the response was produced by timeout.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with state held in a register.
REQ-018 IDLE: if any req is high, the FSM SHALL grant one requester, assert its ack combinationally in that cycle, capture its a/b and id, and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: with both req high, grant the requester other than last_grant; with one req high, grant it regardless of last_grant.
REQ-020 last_grant SHALL update on every grant.
REQ-021 At most one ack SHALL be high in any cycle; ack SHALL be 0 outside IDLE.
REQ-022 ISSUE: mul_start=1 for exactly one cycle, then the FSM moves to WAIT, and wait_cnt SHALL clear to 0.
REQ-023 WAIT: if mul_done=1, the block SHALL capture mul_product and clear the error flag, then move to RESP.
REQ-024 WAIT: if mul_done=0 and wait_cnt==TIMEOUT-1, the block SHALL capture product 0 and set the error flag, then move to RESP.
REQ-025 WAIT: otherwise wait_cnt SHALL increment and the FSM SHALL stay in WAIT.
REQ-026 If mul_done arrives on the timeout cycle, mul_done SHALL win (no error).
REQ-027 mul_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-028 RESP: rsp_valid=1 for exactly one cycle, with rsp_id/rsp_product/rsp_err from the captured registers, then the FSM returns to IDLE.
REQ-029 rsp_id/rsp_product/rsp_err SHALL hold their values until the next RESP.
REQ-030 Latency: ack at cycle T, mul_start at T+1, WAIT entered at T+2; mul_done sampled at cycle D gives rsp_valid at D+1; the next grant is possible at D+2.
REQ-031 A request that stays high through its own response SHALL be treated as a new request.
REQ-032 mul_start and rsp_valid SHALL be decoded only from the registered state.

Reset
REQ-033 While rst=1 at a clock edge, state SHALL become IDLE, last_grant=1 (so requester 0 has first priority), and wait_cnt=0.
REQ-034 While rst=1, all captured registers SHALL clear, and mul_start, rsp_valid, rsp_id, rsp_product, rsp_err and busy SHALL be 0.
REQ-035 While rst=1, ack0/ack1 SHALL be forced to 0.
REQ-036 Reset mid-operation SHALL abandon the transaction with no response.
REQ-037 A mul_done arriving after reset SHALL be ignored.

Verification
REQ-038 Bench SHALL cover: req0 with a0=3, b0=5, multiplier model done 6 cycles after start -> ack0 one cycle, mul_start next cycle, rsp_valid with rsp_id=0, rsp_product=15, rsp_err=0.
REQ-039 Bench SHALL cover: req0 and req1 both high right after reset (a0=2,b0=7; a1=15,b1=15) -> ack0 first, response 14/id0, then ack1, response 225/id1.
REQ-040 Bench SHALL cover: both reqs held high continuously for 6 transactions -> grants alternate 0,1,0,1,0,1 with no ack overlap.
REQ-041 Bench SHALL cover: TIMEOUT=8, mul_done tied 0 -> rsp_valid exactly 8 cycles after WAIT entry, rsp_err=1, rsp_product=0, busy low the next cycle.
REQ-042 Bench SHALL cover: mul_done pulsed on the 8th WAIT cycle with TIMEOUT=8, product 42 -> rsp_err=0, rsp_product=42.
REQ-043 Bench SHALL cover: rst=1 for one cycle during WAIT, followed by a late mul_done -> no rsp_valid, busy=0; the next req1 is granted normally.
